// File: rtl/track_collision_scheduler_if.sv
// Car, segment-table and checker bus between the scheduler and its peers.
// Latency: none (wires only).
// Backpressure: none; the scheduler paces every transfer itself.
//
// Signals (names as seen from the scheduler):
//   o_car_sel/o_car_load   car state select and capture strobe
//   o_seg_rd/o_seg_addr    segment table read, i_seg_type returns one cycle later
//   o_chk_type/o_chk_valid checker mux steering and sample strobe
//   i_in_region/i_collision muxed checker results
interface track_collision_scheduler_if #(
    parameter int CAR_IDX_WIDTH = 1,
    parameter int SEG_IDX_WIDTH = 4
);
    logic [CAR_IDX_WIDTH-1:0] o_car_sel;
    logic                     o_car_load;
    logic                     o_seg_rd;
    logic [SEG_IDX_WIDTH-1:0] o_seg_addr;
    logic [1:0]               i_seg_type;
    logic [1:0]               o_chk_type;
    logic                     o_chk_valid;
    logic                     i_in_region;
    logic                     i_collision;

    modport master (
        output o_car_sel, o_car_load, o_seg_rd, o_seg_addr, o_chk_type, o_chk_valid,
        input  i_seg_type, i_in_region, i_collision
    );

    modport slave (
        input  o_car_sel, o_car_load, o_seg_rd, o_seg_addr, o_chk_type, o_chk_valid,
        output i_seg_type, i_in_region, i_collision
    );
endinterface

// File: rtl/track_collision_scheduler.sv
// Per-frame sequencer sharing one set of track collision checkers across all cars.
// Latency: per car 1 + 3*S (+2 when END is read), +1 for DONE, from accepted i_start to o_done.
// Backpressure: none; i_start is ignored while o_busy, results held until the next accepted start.
//
// Ports: i_clk, i_rst_n (async active-low), i_start/o_busy/o_done frame control,
//   bus (master modport: car bus, segment table read port, checker mux/strobe and results),
//   o_collision/o_off_track per-car flags, o_hit_seg per-car first colliding segment (car k at [k*W +: W]).
// Optional feature: define TRACK_COLL_EARLY_EXIT_EN to stop scanning a car at its first collision.
module track_collision_scheduler #(
    parameter int NUM_CARS      = 2,
    parameter int CAR_IDX_WIDTH = 1,
    parameter int NUM_SEGMENTS  = 16,
    parameter int SEG_IDX_WIDTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    output logic                              o_busy,
    output logic                              o_done,
    track_collision_scheduler_if.master       bus,
    output logic [NUM_CARS-1:0]               o_collision,
    output logic [NUM_CARS-1:0]               o_off_track,
    output logic [NUM_CARS*SEG_IDX_WIDTH-1:0] o_hit_seg
);
    localparam logic [1:0] SEG_END = 2'b11;
    localparam logic [SEG_IDX_WIDTH-1:0] SEG_LAST = SEG_IDX_WIDTH'(NUM_SEGMENTS - 1);
    localparam logic [CAR_IDX_WIDTH-1:0] CAR_LAST = CAR_IDX_WIDTH'(NUM_CARS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_EVAL, S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [CAR_IDX_WIDTH-1:0]          car_q, car_d;
    logic [SEG_IDX_WIDTH-1:0]          seg_q, seg_d;
    logic [1:0]                        chk_type_q, chk_type_d;
    logic                              hit_found_q, hit_found_d;
    logic [NUM_CARS-1:0]               coll_q, coll_d;
    logic [NUM_CARS-1:0]               off_q, off_d;
    logic [NUM_CARS*SEG_IDX_WIDTH-1:0] hit_q, hit_d;
    logic                              next_car;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            car_q       <= '0;
            seg_q       <= '0;
            chk_type_q  <= '0;
            hit_found_q <= 1'b0;
            coll_q      <= '0;
            off_q       <= '0;
            hit_q       <= '0;
        end else begin
            state_q     <= state_d;
            car_q       <= car_d;
            seg_q       <= seg_d;
            chk_type_q  <= chk_type_d;
            hit_found_q <= hit_found_d;
            coll_q      <= coll_d;
            off_q       <= off_d;
            hit_q       <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        car_d       = car_q;
        seg_d       = seg_q;
        chk_type_d  = chk_type_q;
        hit_found_d = hit_found_q;
        coll_d      = coll_q;
        off_d       = off_q;
        hit_d       = hit_q;
        next_car    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    coll_d  = '0;
                    hit_d   = '0;
                    off_d   = '1;   // every car is off-track until some segment claims it
                    car_d   = '0;
                    seg_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                hit_found_d = 1'b0;
                state_d     = S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                chk_type_d = bus.i_seg_type;
                if (bus.i_seg_type == SEG_END) next_car = 1'b1;
                else                           state_d  = S_EVAL;
            end
            S_EVAL: begin
                if (bus.i_in_region) off_d[car_q] = 1'b0;
                if (bus.i_collision) begin
                    coll_d[car_q] = 1'b1;
                    // Segments are walked in ascending order, so the first hit is the lowest index.
                    if (!hit_found_q) begin
                        hit_d[int'(car_q)*SEG_IDX_WIDTH +: SEG_IDX_WIDTH] = seg_q;
                        hit_found_d = 1'b1;
                    end
                end
`ifdef TRACK_COLL_EARLY_EXIT_EN
                if (bus.i_collision) begin
                    off_d[car_q] = 1'b0;  // a collision can only happen inside a region
                    next_car     = 1'b1;
                end else
`endif
                if (seg_q == SEG_LAST) begin
                    next_car = 1'b1;
                end else begin
                    seg_d   = seg_q + SEG_IDX_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Advance to the next car or finish; the counters saturate rather than wrap.
        if (next_car) begin
            seg_d = '0;
            if (car_q == CAR_LAST) begin
                state_d = S_DONE;
            end else begin
                car_d   = car_q + CAR_IDX_WIDTH'(1);
                state_d = S_LOAD;
            end
        end
    end

    always_comb begin
        o_busy          = (state_q != S_IDLE);
        o_done          = (state_q == S_DONE);
        bus.o_car_load  = (state_q == S_LOAD);
        bus.o_car_sel   = car_q;
        bus.o_seg_rd    = (state_q == S_FETCH);
        bus.o_seg_addr  = seg_q;
        bus.o_chk_type  = chk_type_q;
        bus.o_chk_valid = (state_q == S_EVAL);
        o_collision     = coll_q;
        o_off_track     = off_q;
        o_hit_seg       = hit_q;
    end
endmodule

// File: tb/tb_track_collision_scheduler.sv
module tb_track_collision_scheduler;
    localparam int NC = 2;
    localparam int CW = 1;
    localparam int NS = 16;
    localparam int SW = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic [NC-1:0]     o_collision;
    logic [NC-1:0]     o_off_track;
    logic [NC*SW-1:0]  o_hit_seg;

    track_collision_scheduler_if #(.CAR_IDX_WIDTH(CW), .SEG_IDX_WIDTH(SW)) bus();

    track_collision_scheduler #(
        .NUM_CARS(NC), .CAR_IDX_WIDTH(CW), .NUM_SEGMENTS(NS), .SEG_IDX_WIDTH(SW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .bus         (bus),
        .o_collision (o_collision),
        .o_off_track (o_off_track),
        .o_hit_seg   (o_hit_seg)
    );

    always #5 i_clk = ~i_clk;

    // Environment: segment table ROM (1-cycle read) and per-car/per-segment checker answers.
    logic [1:0] seg_tab [NS];
    bit         reg_m [NC][NS];
    bit         col_m [NC][NS];
    bit         noise;

    always @(posedge i_clk) begin
        noise <= 1'($urandom);
        if (bus.o_seg_rd) bus.i_seg_type <= seg_tab[bus.o_seg_addr];
    end

    // Outside EVAL the checker outputs are junk; the scheduler must ignore them.
    assign bus.i_in_region = bus.o_chk_valid ? reg_m[bus.o_car_sel][bus.o_seg_addr] : noise;
    assign bus.i_collision = bus.o_chk_valid ? col_m[bus.o_car_sel][bus.o_seg_addr] : noise;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the table per car and derive results, cycle count and EVAL order.
    logic [NC-1:0]    exp_coll, exp_off;
    logic [NC*SW-1:0] exp_hit;
    int               exp_cycles, exp_rd;
    int               q_car[$];
    int               q_seg[$];

    task automatic model();
        bit found;
        q_car.delete();
        q_seg.delete();
        exp_coll = '0; exp_off = '1; exp_hit = '0;
        exp_cycles = 0; exp_rd = 0;
        for (int c = 0; c < NC; c++) begin
            found = 1'b0;
            exp_cycles += 1;
            for (int s = 0; s < NS; s++) begin
                exp_cycles += 2;
                exp_rd++;
                if (seg_tab[s] == 2'b11) break;
                exp_cycles += 1;
                q_car.push_back(c);
                q_seg.push_back(s);
                if (reg_m[c][s]) exp_off[c] = 1'b0;
                if (col_m[c][s]) begin
                    exp_coll[c] = 1'b1;
                    if (!found) begin
                        exp_hit[c*SW +: SW] = SW'(s);
                        found = 1'b1;
                    end
`ifdef TRACK_COLL_EARLY_EXIT_EN
                    exp_off[c] = 1'b0;
                    break;
`endif
                end
            end
        end
        exp_cycles += 1;
    endtask

    int last_k;
    int evals;

    // One frame: pulse i_start, then compare the DUT against the model every cycle until o_done.
    task automatic run_frame(input bit mid_start);
        int  k, loads, rds, e_car, e_seg;
        bit  seen_done;
        model();
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        k = 1; loads = 0; rds = 0; evals = 0; seen_done = 1'b0;
        while (!seen_done && k <= 2000) begin
            if (bus.o_car_load) loads++;
            if (bus.o_seg_rd) rds++;
            if (bus.o_chk_valid) begin
                evals++;
                if (q_car.size() == 0) begin
                    check("extra_eval", 1, 0);
                end else begin
                    e_car = q_car.pop_front();
                    e_seg = q_seg.pop_front();
                    check("eval_car", 64'(bus.o_car_sel), 64'(e_car));
                    check("eval_seg", 64'(bus.o_seg_addr), 64'(e_seg));
                    check("eval_type", 64'(bus.o_chk_type), 64'(seg_tab[e_seg]));
                end
            end
            check("busy", 64'(o_busy), 1);
            if (o_done) begin
                seen_done = 1'b1;
                last_k = k;
                check("done_cycle", 64'(k), 64'(exp_cycles));
                check("collision", 64'(o_collision), 64'(exp_coll));
                check("off_track", 64'(o_off_track), 64'(exp_off));
                check("hit_seg", 64'(o_hit_seg), 64'(exp_hit));
                check("car_loads", 64'(loads), 64'(NC));
                check("seg_reads", 64'(rds), 64'(exp_rd));
                check("evals_left", 64'(q_car.size()), 0);
                i_start = 1'b1;  // request inside the DONE cycle must be dropped
                @(negedge i_clk) i_start = 1'b0;
                check("start_in_done_ignored", 64'(o_busy), 0);
                check("results_held", 64'({o_collision, o_off_track, o_hit_seg}),
                      64'({exp_coll, exp_off, exp_hit}));
            end else begin
                i_start = (mid_start && (k == 10 || k == 40));
                @(negedge i_clk);
                k++;
            end
        end
        i_start = 1'b0;
        if (!seen_done) check("done_timeout", 0, 1);
    endtask

    task automatic clear_env();
        for (int s = 0; s < NS; s++) begin
            seg_tab[s] = 2'b11;
            for (int c = 0; c < NC; c++) begin
                reg_m[c][s] = 1'b0;
                col_m[c][s] = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({o_busy, o_done, o_collision, o_off_track, o_hit_seg, bus.o_car_sel,
                         bus.o_car_load, bus.o_seg_rd, bus.o_seg_addr, bus.o_chk_type,
                         bus.o_chk_valid}), 0);
    endtask

    initial begin
        int end_pos, waited;
        clear_env();

        // Reset state
        repeat (3) @(negedge i_clk);
        check_all_zero("reset_outputs");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all_zero("idle_after_reset");

        // Directed: {H,V,C,END}, car0 region+collision at seg1, car1 region at seg0
        clear_env();
        seg_tab[0] = 2'b00; seg_tab[1] = 2'b01; seg_tab[2] = 2'b10;
        reg_m[0][1] = 1'b1; col_m[0][1] = 1'b1; reg_m[1][0] = 1'b1;
        run_frame(1'b0);
        check("A_collision", 64'(o_collision), 64'(2'b01));
        check("A_off_track", 64'(o_off_track), 64'(2'b00));
        check("A_hit_car0", 64'(o_hit_seg[3:0]), 1);
        check("A_hit_car1", 64'(o_hit_seg[7:4]), 0);
`ifdef TRACK_COLL_EARLY_EXIT_EN
        check("A_latency", 64'(last_k), 20);
`else
        check("A_latency", 64'(last_k), 25);
`endif

        // Corner: car0 collides at seg0 and seg2
        clear_env();
        seg_tab[0] = 2'b00; seg_tab[1] = 2'b01; seg_tab[2] = 2'b10;
        reg_m[0][0] = 1'b1; col_m[0][0] = 1'b1; reg_m[0][2] = 1'b1; col_m[0][2] = 1'b1;
        run_frame(1'b0);
        check("corner_hit_car0", 64'(o_hit_seg[3:0]), 0);
        check("corner_collision", 64'(o_collision), 64'(2'b01));
        check("corner_off_track", 64'(o_off_track), 64'(2'b10));

        // END at address 0
        clear_env();
        for (int s = 0; s < NS; s++) reg_m[0][s] = 1'b1;
        run_frame(1'b0);
        check("end0_off_track", 64'(o_off_track), 64'(2'b11));
        check("end0_collision", 64'(o_collision), 0);
        check("end0_latency", 64'(last_k), 7);

        // Full table, no END, i_start pulsed mid-scan
        clear_env();
        for (int s = 0; s < NS; s++) begin
            seg_tab[s] = 2'($urandom_range(0, 2));
            for (int c = 0; c < NC; c++) begin
                reg_m[c][s] = ($urandom_range(0, 3) == 0);
                col_m[c][s] = 1'b0;
            end
        end
        run_frame(1'b1);
`ifndef TRACK_COLL_EARLY_EXIT_EN
        check("full_eval_count", 64'(evals), 32);
        check("full_latency", 64'(last_k), 2 * (1 + 3 * 16) + 1);
`endif

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            clear_env();
            end_pos = $urandom_range(0, NS);
            for (int s = 0; s < NS; s++) begin
                seg_tab[s] = (s == end_pos) ? 2'b11 : 2'($urandom_range(0, 3));
                for (int c = 0; c < NC; c++) begin
                    reg_m[c][s] = ($urandom_range(0, 3) == 0);
                    col_m[c][s] = ($urandom_range(0, 5) == 0);
                end
            end
            run_frame(f[0]);
        end

        // Async reset mid-scan at car 1, seg 2
        clear_env();
        for (int s = 0; s < NS; s++) seg_tab[s] = 2'b00;
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        waited = 0;
        while (!(bus.o_car_sel == 1'b1 && bus.o_seg_addr == 4'd2) && waited < 500) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 500) check("reset_scan_timeout", 0, 1);
        check("busy_before_reset", 64'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("mid_scan_reset");
        @(negedge i_clk);
        check_all_zero("reset_held");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_after_mid_reset", 64'(o_busy), 0);

        // Scheduler still works after the reset
        clear_env();
        seg_tab[0] = 2'b10; seg_tab[1] = 2'b00;
        reg_m[1][1] = 1'b1; col_m[1][1] = 1'b1;
        run_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
